// File: rtl/start_token_srl_fifo_ctrl_pkg.sv
// Shared types and constants for the start-token SRL FIFO controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The pointer is one bit wider than the read address so that it can
// represent -1 (empty) through DEPTH-1 (full) in a signed sense.
package start_token_srl_fifo_ctrl_pkg;

    // Widest pointer any instance is expected to need.
    localparam int MAX_PTR_W = 32;

    // Pointer value that means "no entries". It is truncated to the
    // instance pointer width, where it is still all-ones (-1).
    localparam logic [MAX_PTR_W-1:0] PTR_EMPTY = '1;

    // Occupancy / pointer-sized scratch type used for parameter math.
    typedef logic [MAX_PTR_W-1:0] occ_t;

    // Per-cycle operation selected by the gated push/pop pair.
    // Encoding is {push, pop} so the controller can cast directly.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Pointer width for a given read-address width: one extra sign bit.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/start_token_srl_fifo_ctrl_srl_token_store.sv
// Shift-register token store: write shifts everything up one slot and loads slot 0.
// Latency: write visible on dout the cycle after the edge; read path is combinational.
// Backpressure: none here; the controller gates we so the array never over-runs.
//
// Ports:
//   clk   clock
//   we    shift enable (one token loaded into slot 0 per enabled edge)
//   addr  read address, slot 0 holds the newest token
//   din   token to load
//   dout  token at slot addr
//
// No reset on the array on purpose: a reset-free shift chain with a
// single enable maps onto shift-register LUT primitives.
module srl_token_store #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Explicit decode rather than mem[addr] so that address codes beyond
    // DEPTH-1 (including the empty pointer's low bits when DEPTH is not a
    // power of two) fall back to a defined slot instead of an out-of-range
    // array access. Data is a don't-care whenever that happens.
    always_comb begin
        dout = mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                dout = mem[i];
            end
        end
    end

endmodule

// File: rtl/start_token_srl_fifo_ctrl.sv
// First-word-fall-through FIFO controller for start tokens over an SRL store.
// Latency: one cycle write-to-read; head data is combinational from the store.
// Backpressure: if_full_n low refuses writes, if_empty_n low refuses reads; refused requests have no effect.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   if_write_ce, if_write     producer write enable / request
//   if_din                    producer token
//   if_full_n                 1 = space available
//   if_read_ce, if_read       consumer read enable / request
//   if_dout                   head-of-queue token (valid while if_empty_n)
//   if_empty_n                1 = head token valid
//   if_count                  occupancy 0..DEPTH
module start_token_srl_fifo_ctrl
    import start_token_srl_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(PTR_EMPTY);
    // A push from this pointer value fills the last slot.
    localparam occ_t             FULL_TRIG = occ_t'(DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_FULL_TRIG = PTR_W'(FULL_TRIG);

    // ptr holds (occupancy - 1): -1 when empty, DEPTH-1 when full.
    // Because slot 0 is always the newest token, ptr is also the
    // address of the oldest one.
    logic [PTR_W-1:0] ptr;
    logic             full_n_q;
    logic             empty_n_q;

    logic push;
    logic pop;
    op_e  op;

    // Requests against a full or empty queue are dropped here, so the
    // store and pointer never see them.
    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read  & if_read_ce  & empty_n_q;
    assign op   = op_e'({push, pop});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= PTR_RESET;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            case (op)
                OP_PUSH: begin
                    ptr       <= ptr + PTR_W'(1);
                    empty_n_q <= 1'b1;
                    if (ptr == PTR_FULL_TRIG) begin
                        full_n_q <= 1'b0;
                    end
                end
                OP_POP: begin
                    ptr      <= ptr - PTR_W'(1);
                    full_n_q <= 1'b1;
                    if (ptr == '0) begin
                        empty_n_q <= 1'b0;
                    end
                end
                // OP_BOTH: the shift slides the next-oldest token into
                // slot ptr, which is exactly the new head, so nothing
                // in the controller has to move.
                default: begin
                end
            endcase
        end
    end

    srl_token_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_store (
        .clk  (clk),
        .we   (push),
        .addr (ptr[ADDR_WIDTH-1:0]),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_count   = ptr + PTR_W'(1);

endmodule

// File: tb/tb_start_token_srl_fifo_ctrl.sv
module tb_start_token_srl_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   if_count;

    int tests = 0;
    int fails = 0;

    // Reference model: plain queue of tokens, oldest at index 0.
    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    start_token_srl_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read_ce  (if_read_ce),
        .if_read     (if_read),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n),
        .if_count    (if_count)
    );

    // Occupancy (pointer + 1) must stay within 0..DEPTH.
    always @(negedge clk) begin
        if (reset_n) begin
            assert (if_count <= DEPTH)
                else $error("pointer out of range, count=%0d", if_count);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_outputs(input string tag);
        check({tag, ".count"},   32'(if_count),   32'(model_q.size()));
        check({tag, ".empty_n"}, 32'(if_empty_n), 32'(model_q.size() != 0));
        check({tag, ".full_n"},  32'(if_full_n),  32'(model_q.size() < DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".dout"}, 32'(if_dout), 32'(model_q[0]));
        end
    endtask

    // Called just after a negedge: drive inputs, take one posedge, update
    // the model from the pre-edge state, then check at the next negedge.
    task automatic step(input logic w, input logic wce, input logic r,
                        input logic rce, input logic [DW-1:0] d, input string tag);
        bit do_push;
        bit do_pop;
        if_write    = w;
        if_write_ce = wce;
        if_read     = r;
        if_read_ce  = rce;
        if_din      = d;
        do_push = w && wce && (model_q.size() < DEPTH);
        do_pop  = r && rce && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Reset pulse placed between clock edges; flags must react at once.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        model_q.delete();
        #1;
        check_outputs(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        if_din      = '0;

        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;
        step(0, 0, 0, 0, 8'h00, "idle");
        check("idle.count", 32'(if_count), 32'd0);

        // Fill with four tokens.
        step(1, 1, 0, 0, 8'h11, "fill1");
        check("fill1.dout", 32'(if_dout), 32'h11);
        step(1, 1, 0, 0, 8'h22, "fill2");
        step(1, 1, 0, 0, 8'h33, "fill3");
        step(1, 1, 0, 0, 8'h44, "fill4");
        check("fill4.full_n", 32'(if_full_n), 32'd0);
        check("fill4.count", 32'(if_count), 32'd4);

        // Write while full is dropped, then drain.
        step(1, 1, 0, 0, 8'h55, "ovf");
        check("ovf.dout", 32'(if_dout), 32'h11);
        step(0, 0, 1, 1, 8'h00, "rd1");
        check("rd1.dout", 32'(if_dout), 32'h22);
        step(0, 0, 1, 1, 8'h00, "rd2");
        step(0, 0, 1, 1, 8'h00, "rd3");
        check("rd3.dout", 32'(if_dout), 32'h44);
        step(0, 0, 1, 1, 8'h00, "rd4");
        check("rd4.empty_n", 32'(if_empty_n), 32'd0);
        step(0, 0, 1, 1, 8'h00, "udf");

        // Simultaneous push/pop at occupancy 2.
        step(1, 1, 0, 0, 8'hA0, "sim_a0");
        step(1, 1, 0, 0, 8'hA1, "sim_a1");
        step(1, 1, 1, 1, 8'hA2, "sim_both");
        check("sim_both.count", 32'(if_count), 32'd2);
        check("sim_both.dout", 32'(if_dout), 32'hA1);
        step(0, 0, 1, 1, 8'h00, "sim_pop");
        check("sim_pop.dout", 32'(if_dout), 32'hA2);
        step(0, 0, 1, 1, 8'h00, "sim_drain");

        // Empty with both requests: only the push lands.
        step(1, 1, 1, 1, 8'h7E, "empty_both");
        check("empty_both.count", 32'(if_count), 32'd1);
        check("empty_both.dout", 32'(if_dout), 32'h7E);

        // Clock-enable low blocks the write.
        step(1, 0, 0, 0, 8'hEE, "wce_off");
        check("wce_off.count", 32'(if_count), 32'd1);
        step(0, 1, 1, 0, 8'h00, "rce_off");
        check("rce_off.count", 32'(if_count), 32'd1);

        // Reset mid-stream at occupancy 3.
        step(1, 1, 0, 0, 8'h21, "pre_rst1");
        step(1, 1, 0, 0, 8'h31, "pre_rst2");
        check("pre_rst.count", 32'(if_count), 32'd3);
        async_reset("midrst");
        check("midrst.count", 32'(if_count), 32'd0);
        step(1, 1, 0, 0, 8'h5A, "post_rst");
        check("post_rst.dout", 32'(if_dout), 32'h5A);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                async_reset("rnd_rst");
            end
            step(1'($urandom), 1'($urandom_range(3) != 0),
                 1'($urandom), 1'($urandom_range(3) != 0),
                 8'($urandom), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/start_token_srl_fifo_ctrl.md
Name: start_token_srl_fifo_ctrl

Overview:
- Controller that turns a DEPTH-entry shift-register store into a first-word-fall-through FIFO for the start tokens passed between dataflow processes.
- Generates the shift enable and read address for the store and tracks occupancy.
- Exposes the write/read handshake the producer and consumer processes use.
- One instance per start-token channel, between a producer process's start output and a consumer process's start input.

Parameters:
- DATA_WIDTH, 1, token width in bits
- ADDR_WIDTH, 1, read-address width; requires 2^ADDR_WIDTH >= DEPTH
- DEPTH, 2, entry count; must be >= 2

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- if_write_ce  in  1  write clock-enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_full_n  out  1  1 = space available
- if_read_ce  in  1  read clock-enable
- if_read  in  1  read request
- if_dout  out  DATA_WIDTH  head-of-queue data, combinational
- if_empty_n  out  1  1 = head data valid
- if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Definitions:
  - push = if_write & if_write_ce & if_full_n
  - pop = if_read & if_read_ce & if_empty_n
  - Handshake rule: a write or read request presented while full or empty is ignored, with no side effect.
- Internal pointer ptr, ADDR_WIDTH+1 bits, signed sense:
  - reset value all-ones (-1 = empty)
  - ptr+1 is the occupancy, so if_count = ptr+1 (registered value).
- Asynchronous reset (reset_n low):
  - ptr = all-ones, if_empty_n = 0, if_full_n = 1, if_count = 0.
  - Storage is not reset; if_dout is don't-care while if_empty_n = 0.
  - Reset asserted mid-operation discards all queued tokens immediately.
- Store update, on each clk edge where push = 1:
  - entry[i+1] <= entry[i] for all i, then entry[0] <= if_din.
  - Without push, entries hold.
- if_dout = entry[ptr[ADDR_WIDTH-1:0]]. This gives zero-cycle read latency: head data is valid in the same cycle if_empty_n is high.
- Pointer and flags, per clk edge:
  - push & !pop: ptr <= ptr+1; if_empty_n <= 1; if ptr == DEPTH-2 then if_full_n <= 0.
  - pop & !push: ptr <= ptr-1; if_full_n <= 1; if ptr == 0 then if_empty_n <= 0.
  - push & pop: ptr unchanged, flags unchanged. The shift moves the next-oldest entry into slot ptr.
  - neither: hold.
- Latency: a token written at edge N is visible on if_dout with if_empty_n = 1 after edge N (one cycle write-to-read).
- Boundary conditions:
  - Empty with simultaneous write and read requests: only the push happens (pop is gated by if_empty_n = 0).
  - Full with simultaneous requests: only the pop happens; if_full_n rises after that edge.
  - Pointer never leaves the range -1..DEPTH-1; an assertion in the bench checks this.
- Read and write controls are independent, with no priority between producer and consumer.

Decomposition:
- Shared package: localparam helper for the pointer width (ADDR_WIDTH+1), the PTR_EMPTY all-ones constant, and the occupancy typedef.
- One sub-module: srl_token_store. It holds the clocked shift array (we, addr, din, dout) with no reset, so synthesis infers SRLs.
- The controller owns ptr, the flags, and the push/pop gating.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4):
- Reset, then idle -> if_empty_n = 0, if_full_n = 1, if_count = 0. Assert reset_n low between edges -> flags return to reset values immediately, without waiting for a clk edge.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, no reads -> if_count steps 1, 2, 3, 4; if_full_n = 0 after the 4th edge; if_dout = 0x11 from after the 1st edge.
- Full; 5th write 0x55 with if_write = 1 -> ignored. Then read four times -> if_dout sequence 0x11, 0x22, 0x33, 0x44; if_empty_n = 0 after the 4th read.
- Occupancy 2 (0xA0, 0xA1); simultaneous push 0xA2 and pop -> if_count stays 2, if_dout becomes 0xA1, then 0xA2 on the next pop.
- Empty; if_write and if_read both high with 0x7E -> no underflow; if_count = 1, if_dout = 0x7E.
- Write with if_write_ce = 0 at occupancy 1 -> no change. Mid-stream reset at occupancy 3 -> if_count = 0, and a subsequent write of 0x5A reads back 0x5A.
